// File: rtl/cache_read_ctrl.sv
// Read-side controller for a direct-mapped cache: tag lookup, miss fill from memory, CPU response.
// Latency: hit -> cpu_ready 2 cycles after accept; miss -> 3+W cycles (W = memory wait cycles).
// Backpressure: one request in flight; cpu_rd only sampled in IDLE (not queued), memory via mem_rd/mem_ready hold.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_cpu_rd, i_cpu_addr           CPU load request and word address
//   o_cpu_data, o_cpu_ready        response data (held) and one-cycle valid pulse
//   o_busy                         high whenever the controller is not idle
//   o_cache_addr                   registered request address to the storage array
//   i_cache_tag/valid/rdata        combinational array read at o_cache_addr index
//   o_cache_write, o_cache_wdata   one-cycle line-fill strobe and fill data
//   o_mem_rd, o_mem_addr           memory read request, held until i_mem_ready sampled
//   i_mem_ready, i_mem_rdata       memory data valid and read data
//   o_hit_count, o_miss_count      saturating statistics counters
module cache_read_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int INDEX_W = 12,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cpu_rd,
    input  logic [ADDR_W-1:0]           i_cpu_addr,
    output logic [DATA_W-1:0]           o_cpu_data,
    output logic                        o_cpu_ready,
    output logic                        o_busy,
    output logic [ADDR_W-1:0]           o_cache_addr,
    input  logic [ADDR_W-INDEX_W-1:0]   i_cache_tag,
    input  logic                        i_cache_valid,
    input  logic [DATA_W-1:0]           i_cache_rdata,
    output logic                        o_cache_write,
    output logic [DATA_W-1:0]           o_cache_wdata,
    output logic                        o_mem_rd,
    output logic [ADDR_W-1:0]           o_mem_addr,
    input  logic                        i_mem_ready,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic [CNT_W-1:0]            o_hit_count,
    output logic [CNT_W-1:0]            o_miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_WAIT = 3'd2,
        FILL     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_cpu_data;
    logic                r_cpu_ready;
    logic                r_busy;
    logic                r_cache_write;
    logic [DATA_W-1:0]   r_cache_wdata;
    logic                r_mem_rd;
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    logic [TAG_W-1:0]    w_req_tag;
    logic                w_hit;

    assign w_req_tag = r_req_addr[ADDR_W-1:INDEX_W];
    // Array read is combinational from o_cache_addr, so the lookup result is ready in LOOKUP.
    assign w_hit     = i_cache_valid && (i_cache_tag == w_req_tag);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_req_addr    <= '0;
            r_cpu_data    <= '0;
            r_cpu_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_cache_write <= 1'b0;
            r_cache_wdata <= '0;
            r_mem_rd      <= 1'b0;
            r_hit_count   <= '0;
            r_miss_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_rd) begin
                        r_req_addr <= i_cpu_addr;
                        r_busy     <= 1'b1;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_cpu_data  <= i_cache_rdata;
                        r_cpu_ready <= 1'b1;
                        if (r_hit_count != '1) begin
                            r_hit_count <= r_hit_count + CNT_W'(1);
                        end
                        r_state     <= RESP;
                    end else begin
                        r_mem_rd <= 1'b1;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + CNT_W'(1);
                        end
                        r_state  <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // mem_rd stays high until the edge that samples mem_ready.
                    if (i_mem_ready) begin
                        r_cpu_data    <= i_mem_rdata;
                        r_cache_wdata <= i_mem_rdata;
                        r_mem_rd      <= 1'b0;
                        r_cache_write <= 1'b1;
                        r_state       <= FILL;
                    end
                end
                FILL: begin
                    r_cache_write <= 1'b0;
                    r_cpu_ready   <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: begin
                    r_cpu_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_cpu_ready   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_cache_write <= 1'b0;
                    r_mem_rd      <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign o_cpu_data    = r_cpu_data;
    assign o_cpu_ready   = r_cpu_ready;
    assign o_busy        = r_busy;
    assign o_cache_addr  = r_req_addr;
    assign o_cache_write = r_cache_write;
    assign o_cache_wdata = r_cache_wdata;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_addr    = r_req_addr;
    assign o_hit_count   = r_hit_count;
    assign o_miss_count  = r_miss_count;

endmodule

// File: tb/tb_cache_read_ctrl.sv
// Directed bench for cache_read_ctrl: array model + memory model with programmable wait.
// Latency: n/a.
// Backpressure: memory model drives mem_ready after a set number of mem_rd cycles.
module tb_cache_read_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic        cpu_rd;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready, busy, cache_write, mem_rd, cache_valid;
    logic [14:0] cache_addr, mem_addr;
    logic [2:0]  cache_tag;
    logic [31:0] cache_rdata, cache_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    // saturation instance
    logic        cpu_rd_s;
    logic [14:0] cpu_addr_s;
    logic [31:0] cpu_data_s;
    logic        cpu_ready_s, busy_s, cache_write_s, mem_rd_s, cache_valid_s;
    logic [14:0] cache_addr_s, mem_addr_s;
    logic [2:0]  cache_tag_s;
    logic [31:0] cache_rdata_s, cache_wdata_s;
    logic        mem_ready_s;
    logic [31:0] mem_rdata_s;
    logic [1:0]  hit_count_s, miss_count_s;

    cache_read_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_rd(cpu_rd), .i_cpu_addr(cpu_addr),
        .o_cpu_data(cpu_data), .o_cpu_ready(cpu_ready), .o_busy(busy),
        .o_cache_addr(cache_addr), .i_cache_tag(cache_tag), .i_cache_valid(cache_valid),
        .i_cache_rdata(cache_rdata), .o_cache_write(cache_write), .o_cache_wdata(cache_wdata),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_ready(mem_ready),
        .i_mem_rdata(mem_rdata), .o_hit_count(hit_count), .o_miss_count(miss_count)
    );

    cache_read_ctrl #(.CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_rd(cpu_rd_s), .i_cpu_addr(cpu_addr_s),
        .o_cpu_data(cpu_data_s), .o_cpu_ready(cpu_ready_s), .o_busy(busy_s),
        .o_cache_addr(cache_addr_s), .i_cache_tag(cache_tag_s), .i_cache_valid(cache_valid_s),
        .i_cache_rdata(cache_rdata_s), .o_cache_write(cache_write_s), .o_cache_wdata(cache_wdata_s),
        .o_mem_rd(mem_rd_s), .o_mem_addr(mem_addr_s), .i_mem_ready(mem_ready_s),
        .i_mem_rdata(mem_rdata_s), .o_hit_count(hit_count_s), .o_miss_count(miss_count_s)
    );

    // direct-mapped array model, shared by both instances; single writer process
    logic [2:0]  arr_tag   [4096];
    logic        arr_valid [4096];
    logic [31:0] arr_data  [4096];
    logic        arr_clr;
    logic        pre_we;
    logic [11:0] pre_idx;
    logic [2:0]  pre_tag;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 4096; i++) arr_valid[i] <= 1'b0;
        end else begin
            if (pre_we) begin
                arr_valid[pre_idx] <= 1'b1;
                arr_tag[pre_idx]   <= pre_tag;
                arr_data[pre_idx]  <= pre_data;
            end
            if (cache_write) begin
                arr_valid[cache_addr[11:0]] <= 1'b1;
                arr_tag[cache_addr[11:0]]   <= cache_addr[14:12];
                arr_data[cache_addr[11:0]]  <= cache_wdata;
            end
            if (cache_write_s) begin
                arr_valid[cache_addr_s[11:0]] <= 1'b1;
                arr_tag[cache_addr_s[11:0]]   <= cache_addr_s[14:12];
                arr_data[cache_addr_s[11:0]]  <= cache_wdata_s;
            end
        end
    end

    assign cache_valid   = arr_valid[cache_addr[11:0]];
    assign cache_tag     = arr_tag[cache_addr[11:0]];
    assign cache_rdata   = arr_data[cache_addr[11:0]];
    assign cache_valid_s = arr_valid[cache_addr_s[11:0]];
    assign cache_tag_s   = arr_tag[cache_addr_s[11:0]];
    assign cache_rdata_s = arr_data[cache_addr_s[11:0]];

    // memory model: mem_ready rises in the mem_wait-th cycle of mem_rd
    int          mem_wait = 1;
    logic        always_rdy = 1'b0;
    logic [31:0] mem_data = 32'h0;
    int          wk = 0;
    assign mem_rdata = mem_data;

    initial mem_ready = 1'b0;
    always @(negedge clk) begin
        if (mem_rd) wk = wk + 1;
        else        wk = 0;
        mem_ready = always_rdy || (mem_rd && (wk >= mem_wait));
    end

    // monitors (sampled mid-cycle)
    int          mrd_cnt = 0, wr_cnt = 0, rdy_cnt = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [14:0] last_waddr = 15'h0, last_maddr = 15'h0;
    always @(negedge clk) begin
        if (mem_rd) begin
            mrd_cnt    = mrd_cnt + 1;
            last_maddr = mem_addr;
        end
        if (cache_write) begin
            wr_cnt     = wr_cnt + 1;
            last_wdata = cache_wdata;
            last_waddr = cache_addr;
        end
        if (cpu_ready) rdy_cnt = rdy_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] idx, input logic [2:0] tg, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_tag = tg; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one read; lat = cycle number of cpu_ready counted from the accepting edge.
    task automatic do_read(input logic [14:0] a, output int lat);
        int t0;
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = a;
        @(negedge clk);
        t0 = cyc;
        cpu_rd = 1'b0; cpu_addr = 15'($urandom);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (cpu_ready) begin
                lat = cyc - t0 + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, m0, w0, r0, n, found;
        int rc[5];

        rst_n = 1'b0; arr_clr = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_tag = '0; pre_data = '0;
        cpu_rd = 1'b0; cpu_addr = '0; cpu_rd_s = 1'b0; cpu_addr_s = '0;
        mem_ready_s = 1'b0; mem_rdata_s = '0;
        repeat (2) @(negedge clk);
        arr_clr = 1'b0;

        // reset state
        chk("rst_cpu_data",  cpu_data, 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst_busy",      32'(busy), 32'h0);
        chk("rst_cache_addr",32'(cache_addr), 32'h0);
        chk("rst_cache_wr",  32'(cache_write), 32'h0);
        chk("rst_mem_rd",    32'(mem_rd), 32'h0);
        chk("rst_mem_addr",  32'(mem_addr), 32'h0);
        chk("rst_hits",      32'(hit_count), 32'h0);
        chk("rst_misses",    32'(miss_count), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: cold miss, wait 3
        mem_wait = 3; mem_data = 32'hDEADBEEF;
        m0 = mrd_cnt; w0 = wr_cnt;
        do_read(15'h0005, lat);
        chk("t1_latency",   32'(lat), 32'd6);
        chk("t1_cpu_data",  cpu_data, 32'hDEADBEEF);
        chk("t1_mem_rd_cyc",32'(mrd_cnt - m0), 32'd3);
        chk("t1_mem_addr",  32'(last_maddr), 32'h0005);
        chk("t1_writes",    32'(wr_cnt - w0), 32'd1);
        chk("t1_wdata",     last_wdata, 32'hDEADBEEF);
        chk("t1_waddr",     32'(last_waddr), 32'h0005);
        chk("t1_misses",    32'(miss_count), 32'd1);
        chk("t1_hits",      32'(hit_count), 32'd0);

        // 2: hit
        preload(12'h005, 3'b010, 32'h12345678);
        m0 = mrd_cnt; w0 = wr_cnt;
        do_read(15'h2005, lat);
        chk("t2_latency",  32'(lat), 32'd2);
        chk("t2_cpu_data", cpu_data, 32'h12345678);
        chk("t2_no_mem_rd",32'(mrd_cnt - m0), 32'd0);
        chk("t2_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("t2_hits",     32'(hit_count), 32'd1);
        chk("t2_misses",   32'(miss_count), 32'd1);

        // 3: tag mismatch at same index
        mem_wait = 1; mem_data = 32'hCAFEF00D;
        m0 = mrd_cnt; w0 = wr_cnt;
        do_read(15'h7005, lat);
        chk("t3_latency",  32'(lat), 32'd4);
        chk("t3_cpu_data", cpu_data, 32'hCAFEF00D);
        chk("t3_mem_addr", 32'(last_maddr), 32'h7005);
        chk("t3_writes",   32'(wr_cnt - w0), 32'd1);
        chk("t3_arr_tag",  32'(arr_tag[12'h005]), 32'd7);
        chk("t3_arr_data", arr_data[12'h005], 32'hCAFEF00D);
        chk("t3_misses",   32'(miss_count), 32'd2);

        // 4: mem_ready held high, including while idle
        always_rdy = 1'b1; mem_data = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        chk("t4_idle_busy",   32'(busy), 32'd0);
        chk("t4_idle_misses", 32'(miss_count), 32'd2);
        chk("t4_idle_cpurdy", 32'(cpu_ready), 32'd0);
        m0 = mrd_cnt;
        do_read(15'h1234, lat);
        chk("t4_latency",   32'(lat), 32'd4);
        chk("t4_mem_rd_cyc",32'(mrd_cnt - m0), 32'd1);
        chk("t4_cpu_data",  cpu_data, 32'h0BADF00D);
        chk("t4_misses",    32'(miss_count), 32'd3);
        always_rdy = 1'b0;

        // 5: reset during MEM_WAIT
        mem_wait = 10;
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 15'h0100;
        @(negedge clk);
        cpu_rd = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd) begin found = 1; break; end
            @(negedge clk);
        end
        chk("t5_mem_rd_seen", 32'(found), 32'd1);
        @(negedge clk);
        w0 = wr_cnt; r0 = rdy_cnt;
        #3 rst_n = 1'b0;
        #1;
        chk("t5_mem_rd_async", 32'(mem_rd), 32'd0);
        chk("t5_busy",         32'(busy), 32'd0);
        chk("t5_misses",       32'(miss_count), 32'd0);
        chk("t5_hits",         32'(hit_count), 32'd0);
        chk("t5_cpu_data",     cpu_data, 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("t5_no_ready", 32'(rdy_cnt - r0), 32'd0);
        rst_n = 1'b1;
        mem_wait = 2; mem_data = 32'h55AA55AA;
        do_read(15'h0100, lat);
        chk("t5_post_latency", 32'(lat), 32'd5);
        chk("t5_post_data",    cpu_data, 32'h55AA55AA);
        chk("t5_post_misses",  32'(miss_count), 32'd1);

        // 6: CNT_W=2, five back-to-back hits
        preload(12'h010, 3'b001, 32'hA5A5A5A5);
        cpu_addr_s = 15'h1010;
        @(negedge clk);
        cpu_rd_s = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ready_s) begin
                rc[n] = cyc;
                n++;
                if (n == 5) begin
                    cpu_rd_s = 1'b0;
                    break;
                end
            end
        end
        repeat (4) @(negedge clk);
        chk("t6_responses", 32'(n), 32'd5);
        for (int k = 1; k < 5; k++) chk($sformatf("t6_gap%0d", k), 32'(rc[k] - rc[k-1]), 32'd3);
        chk("t6_hits_sat", 32'(hit_count_s), 32'd3);
        chk("t6_misses",   32'(miss_count_s), 32'd0);
        chk("t6_data",     cpu_data_s, 32'hA5A5A5A5);
        chk("t6_idle",     32'(busy_s), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
